// File: rtl/cpu_top_if.sv
// cpu_top_if: board-side signal bundle of the pipelined CPU top.
//   push[3:0]        buttons, active-high (push[2] reset, push[0] issue,
//                    push[1] display-select advance, push[3] unused)
//   sw[7:0]          instruction bits [7:0]
//   sww[7:0]         instruction bits [15:8]
//   led[7:0]         low byte of the most recent write-back value
//   digit_anode[3:0] 4-digit bank anodes, active-low one-hot
//   display[7:0]     4-digit bank segments {dp,g,f,e,d,c,b,a}, active-low
//   anode[7:0]       8-digit bank anodes, active-low one-hot
//   segment[7:0]     8-digit bank segments, same encoding as display
// master = board/stimulus side, slave = CPU side.
interface cpu_top_if;
    logic [3:0] push;
    logic [7:0] sw;
    logic [7:0] sww;
    logic [7:0] led;
    logic [3:0] digit_anode;
    logic [7:0] display;
    logic [7:0] anode;
    logic [7:0] segment;

    modport master (
        output push, sw, sww,
        input  led, digit_anode, display, anode, segment
    );

    modport slave (
        input  push, sw, sww,
        output led, digit_anode, display, anode, segment
    );
endinterface

// File: rtl/cpu_top.sv
// cpu_top: board top of a 3-stage (ID/EX/WB) pipelined 16-bit register CPU.
// Instructions come from {sww, sw} and are issued by push[0]; push[1] steps
// the register shown on the 4-digit bank; push[2] is a synchronous reset.
// Ports:
//   clk  system clock, all logic on the rising edge
//   bus  cpu_top_if.slave (buttons, switches, LEDs, both display banks)
// Parameters:
//   SCAN_BITS  display refresh counter width (>= 3)
//   DB_BITS    debounce counter width (used only with TOP_DEBOUNCE_EN)
// Build option:
//   TOP_DEBOUNCE_EN  defined: push[0]/push[1] are debounced before edge
//                    detection; undefined: edge detection follows the
//                    2-flop synchronizer directly.
module cpu_top #(
    parameter int unsigned SCAN_BITS = 16,
    parameter int unsigned DB_BITS   = 4
) (
    input logic       clk,
    cpu_top_if.slave  bus
);

    // ---------------- reset synchronizer (not debounced) ----------------
    logic rst_meta;
    logic rst;

    always_ff @(posedge clk) begin
        rst_meta <= bus.push[2];
        rst      <= rst_meta;
    end

    // ---------------- button conditioning (push[1], push[0]) ------------
    logic [1:0] btn_s1;
    logic [1:0] btn_s2;
    logic [1:0] btn_lvl;
    logic [1:0] btn_prev;
    logic [1:0] btn_pulse;
    logic       issue_p;
    logic       sel_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            btn_s1 <= bus.push[1:0];
            btn_s2 <= btn_s1;
        end
    end

`ifdef TOP_DEBOUNCE_EN
    localparam logic [DB_BITS-1:0] DB_ONE = DB_BITS'(1);

    for (genvar g = 0; g < 2; g++) begin : g_db
        logic [DB_BITS-1:0] cnt;
        logic               lvl;

        // A new level is accepted only after it differs from the current
        // one for 2^DB_BITS consecutive cycles; any bounce restarts the count.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (btn_s2[g] == lvl) begin
                cnt <= '0;
            end else if (cnt == '1) begin
                cnt <= '0;
                lvl <= btn_s2[g];
            end else begin
                cnt <= cnt + DB_ONE;
            end
        end

        assign btn_lvl[g] = lvl;
    end
`else
    assign btn_lvl = btn_s2;

    // DB_BITS has no effect without the debounce stage.
    if (DB_BITS == 0) begin : g_db_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev  <= '0;
            btn_pulse <= '0;
        end else begin
            btn_prev  <= btn_lvl;
            btn_pulse <= btn_lvl & ~btn_prev;
        end
    end

    assign issue_p = btn_pulse[0];
    assign sel_p   = btn_pulse[1];

    // ---------------- ID stage ----------------
    logic [15:0] regs [8];
    logic [15:0] instr;
    logic [3:0]  id_op;
    logic [2:0]  id_rd;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic [15:0] id_a;
    logic [15:0] id_b;
    logic        id_we;

    // EX / WB pipeline registers
    logic        ex_we;
    logic [3:0]  ex_op;
    logic [2:0]  ex_rd;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [15:0] alu_res;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [15:0] wb_val;

    assign instr = {bus.sww, bus.sw};
    assign id_op = instr[15:12];
    assign id_rd = instr[11:9];
    assign id_rs = instr[8:6];
    assign id_rt = instr[5:3];

    // Operand read with bypass: later assignments win, so EX overrides WB.
    always_comb begin
        id_a = regs[id_rs];
        if (wb_we && wb_rd == id_rs) id_a = wb_val;
        if (ex_we && ex_rd == id_rs) id_a = alu_res;
        if (id_rs == 3'd0)           id_a = '0;

        id_b = regs[id_rt];
        if (wb_we && wb_rd == id_rt) id_b = wb_val;
        if (ex_we && ex_rd == id_rt) id_b = alu_res;
        if (id_rt == 3'd0)           id_b = '0;

        // Immediates ride in the B operand.
        case (id_op)
            4'd7:    id_b = {{10{instr[5]}}, instr[5:0]};
            4'd8:    id_b = {instr[7:0], 8'h00};
            default: ;
        endcase

        id_we = issue_p && (id_op >= 4'd1) && (id_op <= 4'd8);
    end

    // ---------------- EX stage ----------------
    always_comb begin
        case (ex_op)
            4'd1:    alu_res = ex_a + ex_b;
            4'd2:    alu_res = ex_a - ex_b;
            4'd3:    alu_res = ex_a & ex_b;
            4'd4:    alu_res = ex_a | ex_b;
            4'd5:    alu_res = ex_a ^ ex_b;
            4'd6:    alu_res = {15'd0, $signed(ex_a) < $signed(ex_b)};
            4'd7:    alu_res = ex_a + ex_b;
            4'd8:    alu_res = ex_b;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_we  <= 1'b0;
            ex_op  <= '0;
            ex_rd  <= '0;
            ex_a   <= '0;
            ex_b   <= '0;
            wb_we  <= 1'b0;
            wb_rd  <= '0;
            wb_val <= '0;
        end else begin
            ex_we  <= id_we;
            if (issue_p) begin
                ex_op <= id_op;
                ex_rd <= id_rd;
                ex_a  <= id_a;
                ex_b  <= id_b;
            end
            wb_we  <= ex_we;
            wb_rd  <= ex_rd;
            wb_val <= alu_res;
        end
    end

    // ---------------- WB stage: register file and LEDs ----------------
    logic [7:0] led_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                regs[3'(i)] <= '0;
            end
            led_q <= '0;
        end else if (wb_we) begin
            if (wb_rd != 3'd0) regs[wb_rd] <= wb_val;
            led_q <= wb_val[7:0];
        end
    end

    // ---------------- front-panel state ----------------
    localparam logic [SCAN_BITS-1:0] SCAN_ONE = SCAN_BITS'(1);

    logic [15:0]          issue_cnt;
    logic [15:0]          last_instr;
    logic [2:0]           sel;
    logic [SCAN_BITS-1:0] scan;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt  <= '0;
            last_instr <= '0;
            sel        <= '0;
            scan       <= '0;
        end else begin
            scan <= scan + SCAN_ONE;
            if (issue_p) begin
                issue_cnt  <= issue_cnt + 16'd1;
                last_instr <= instr;
            end
            if (sel_p) sel <= sel + 3'd1;
        end
    end

    // ---------------- display multiplexing ----------------
    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;
            4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;
            4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;
            4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;
            4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;
            4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;
            4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;
            4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;
            default: hex7 = 8'h8E;
        endcase
    endfunction

    logic [1:0]  d4_idx;
    logic [2:0]  d8_idx;
    logic [15:0] d4_word;
    logic [31:0] d8_word;

    assign d4_idx  = scan[SCAN_BITS-1 -: 2];
    assign d8_idx  = scan[SCAN_BITS-1 -: 3];
    assign d4_word = regs[sel];
    assign d8_word = {issue_cnt, last_instr};

    always_comb begin
        bus.led         = led_q;
        bus.digit_anode = ~(4'b0001 << d4_idx);
        bus.display     = hex7(d4_word[{d4_idx, 2'b00} +: 4]);
        bus.anode       = ~(8'b0000_0001 << d8_idx);
        bus.segment     = hex7(d8_word[{d8_idx, 2'b00} +: 4]);
    end

endmodule

// File: tb/tb_cpu_top.sv
// tb_cpu_top: directed self-checking bench for cpu_top.
// Drives buttons and switches through cpu_top_if, reads registers back via
// the 4-digit bank (select index) and issue count/last instruction via the
// 8-digit bank, decoding the segment patterns. Works with or without
// TOP_DEBOUNCE_EN; the back-to-back bypass test needs the undebounced path.
module tb_cpu_top;

    localparam int HOLD = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    cpu_top_if bus ();

    cpu_top #(
        .SCAN_BITS(4),
        .DB_BITS  (3)
    ) dut (
        .clk(clk),
        .bus(bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [7:0] SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] seg_to_hex(input logic [7:0] s);
        logic [3:0] r;
        r = 'x;
        for (int i = 0; i < 16; i++) begin
            if (SEG[i] == s) r = 4'(i);
        end
        return r;
    endfunction

    // One full scan of each bank takes 16 cycles with SCAN_BITS=4.
    task automatic read_bank4(output logic [15:0] v);
        v = 'x;
        repeat (16) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (bus.digit_anode == ~(4'b0001 << k))
                    v[k*4 +: 4] = seg_to_hex(bus.display);
            end
        end
    endtask

    task automatic read_bank8(output logic [31:0] v);
        v = 'x;
        repeat (16) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                if (bus.anode == ~(8'b0000_0001 << k))
                    v[k*4 +: 4] = seg_to_hex(bus.segment);
            end
        end
    endtask

    task automatic press(input logic [3:0] mask);
        bus.push = bus.push | mask;
        repeat (HOLD) @(negedge clk);
        bus.push = bus.push & ~mask;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] w);
        {bus.sww, bus.sw} = w;
        press(4'b0001);
    endtask

    task automatic sel_step(input int n);
        repeat (n) press(4'b0010);
    endtask

    logic [15:0] v4;
    logic [31:0] v8;

    initial begin
        bus.push = '0;
        bus.sw   = '0;
        bus.sww  = '0;
        @(negedge clk);

        // reset held for 100 cycles
        bus.push[2] = 1'b1;
        repeat (100) @(negedge clk);
        check("rst_led",   {24'd0, bus.led},         32'h00);
        check("rst_dan",   {28'd0, bus.digit_anode}, 32'hE);
        check("rst_disp",  {24'd0, bus.display},     32'hC0);
        check("rst_anode", {24'd0, bus.anode},       32'hFE);
        check("rst_seg",   {24'd0, bus.segment},     32'hC0);
        bus.push[2] = 1'b0;
        @(negedge clk);
        check("rst_hold_dan", {28'd0, bus.digit_anode}, 32'hE);
        check("rst_hold_seg", {24'd0, bus.segment},     32'hC0);
        repeat (4) @(negedge clk);
        read_bank4(v4);
        check("rst_r0", {16'd0, v4}, 32'h0000);
        read_bank8(v8);
        check("rst_bank8", v8, 32'h0000_0000);

        // LUI r1,0x12
        issue(16'h8212);
        check("lui_led", {24'd0, bus.led}, 32'h00);
        read_bank8(v8);
        check("lui_bank8", v8, 32'h0001_8212);
        sel_step(1);
        read_bank4(v4);
        check("lui_r1", {16'd0, v4}, 32'h1200);

        // ADDI r2,r0,-1
        issue(16'h743F);
        check("addi_led", {24'd0, bus.led}, 32'hFF);
        read_bank8(v8);
        check("addi_bank8", v8, 32'h0002_743F);

        // ADD r3,r2,r2 (wraps)
        issue(16'h1690);
        check("add_led", {24'd0, bus.led}, 32'hFE);

        // SLT r4,r2,r0 (signed: -1 < 0)
        issue(16'h6880);
        check("slt_led", {24'd0, bus.led}, 32'h01);

        // ADD r0,r2,r2: led updates, r0 does not
        issue(16'h1090);
        check("r0w_led", {24'd0, bus.led}, 32'hFE);
        sel_step(2);
        read_bank4(v4);
        check("sel3_r3", {16'd0, v4}, 32'hFFFE);
        sel_step(1);
        read_bank4(v4);
        check("sel4_r4", {16'd0, v4}, 32'h0001);

        // SUB r5,r3,r2 issued together with a select step
        {bus.sww, bus.sw} = 16'h2AD0;
        press(4'b0011);
        check("sub_led", {24'd0, bus.led}, 32'hFF);
        read_bank4(v4);
        check("both_sel5_r5", {16'd0, v4}, 32'hFFFF);
        read_bank8(v8);
        check("sub_bank8", v8, 32'h0006_2AD0);

        // select wraps 7 -> 0, r0 still reads 0
        sel_step(3);
        read_bank4(v4);
        check("wrap_r0", {16'd0, v4}, 32'h0000);

`ifndef TOP_DEBOUNCE_EN
        // ADDI r6,r0,3 then ADD r7,r6,r6 two cycles apart: r6 bypassed from WB
        {bus.sww, bus.sw} = 16'h7C03;
        bus.push[0] = 1'b1;
        @(negedge clk);
        bus.push[0] = 1'b0;
        @(negedge clk);
        bus.push[0] = 1'b1;
        @(negedge clk);
        bus.push[0] = 1'b0;
        @(negedge clk);
        {bus.sww, bus.sw} = 16'h1FB0;
        repeat (HOLD) @(negedge clk);
        check("fwd_led", {24'd0, bus.led}, 32'h06);
        read_bank8(v8);
        check("fwd_bank8", v8, 32'h0008_1FB0);
        sel_step(6);
        read_bank4(v4);
        check("fwd_r6", {16'd0, v4}, 32'h0003);
        sel_step(1);
        read_bank4(v4);
        check("fwd_r7", {16'd0, v4}, 32'h0006);
`endif

        // reset while ADDI r5,r0,5 is in flight
        {bus.sww, bus.sw} = 16'h7A05;
        bus.push[0] = 1'b1;
`ifdef TOP_DEBOUNCE_EN
        repeat (12) @(negedge clk);
`else
        repeat (3) @(negedge clk);
`endif
        bus.push[2] = 1'b1;
        repeat (3) @(negedge clk);
        bus.push[0] = 1'b0;
        repeat (10) @(negedge clk);
        bus.push[2] = 1'b0;
        repeat (HOLD) @(negedge clk);
        check("inflt_led", {24'd0, bus.led}, 32'h00);
        read_bank8(v8);
        check("inflt_bank8", v8, 32'h0000_0000);
        sel_step(5);
        read_bank4(v4);
        check("inflt_r5", {16'd0, v4}, 32'h0000);
        sel_step(6);
        read_bank4(v4);
        check("inflt_r3", {16'd0, v4}, 32'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
